// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Control-flow recovery sequencer for the RISC-V core.
//   - Bimodal BHT of 2-bit saturating counters, indexed by pc[IDX_W+1:2],
//     gives fetch a taken/not-taken prediction.
//   - Trains the BHT with the resolved outcome from EX and detects
//     mispredictions.
//   - On a mispredict issues a one-shot PC redirect and holds flush for
//     FLUSH_CYCLES non-stalled cycles (redirect cycle included).
//
// Parameters:
//   IDX_W         BHT index width, table has 2^IDX_W entries
//   FLUSH_CYCLES  cycles flush is asserted per mispredict, 1..15
//
// Ports:
//   clk              core clock, rising edge
//   rst              synchronous active-high reset
//   if_pc            fetch PC for BHT lookup
//   if_pred_taken    combinational prediction for if_pc (counter MSB)
//   ex_valid         EX stage holds a valid instruction
//   ex_is_branch     EX instruction is a conditional branch
//   ex_taken         resolved branch outcome
//   ex_pred_taken    prediction carried down from fetch
//   ex_pc            PC of the EX instruction
//   ex_target        computed branch target
//   stall            pipeline frozen, EX inputs held stable
//   redirect         load redirect_pc into the PC
//   redirect_pc      corrected fetch address
//   flush            kill IF/ID contents
//   busy             recovery in progress
//   perf_branches    (BRANCH_PERF_CNT_EN) accepted branch count, saturating
//   perf_mispredicts (BRANCH_PERF_CNT_EN) accepted mispredict count, saturating
//
// Optional feature macro: BRANCH_PERF_CNT_EN adds the two perf counters.
//
// State table:
//   state    | meaning
//   IDLE     | evaluating EX branches, no recovery in progress
//   REDIRECT | redirect + flush asserted, waiting for a non-stalled cycle
//   FLUSH    | flush asserted, counting down remaining flush cycles
// ---------------------------------------------------------------------------
module branch_redirect_ctrl #(
    parameter int IDX_W        = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        busy
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
`endif
);

    localparam int BHT_DEPTH = 1 << IDX_W;

    // Remaining FLUSH-state cycles after the redirect cycle, minus one, since
    // the down-counter terminates on zero.
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES >= 2) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       flush_cnt;
    logic [3:0]       flush_cnt_nxt;

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       ctr_old;
    logic [1:0]       ctr_new;

    logic             accept;
    logic             mispredict;
    logic [31:0]      fallthrough_pc;
    logic             unused_if_pc_bits;

    // ------------------------------------------------------------------
    // BHT lookup and training
    // ------------------------------------------------------------------
    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // Only the index bits of the fetch PC matter to the table.
    assign unused_if_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Table is a register array, so a same-cycle write is only visible after
    // the edge: the lookup naturally returns the pre-update counter.
    assign if_pred_taken = bht[if_idx][1];

    assign accept     = (state == IDLE) && ex_valid && ex_is_branch && !stall;
    assign mispredict = accept && (ex_taken != ex_pred_taken);

    assign ctr_old        = bht[ex_idx];
    assign fallthrough_pc = ex_pc + 32'd4;

    always_comb begin
        ctr_new = ctr_old;
        if (ex_taken) begin
            if (ctr_old != 2'b11) ctr_new = ctr_old + 2'd1;
        end else begin
            if (ctr_old != 2'b00) ctr_new = ctr_old - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (accept) begin
            bht[ex_idx] <= ctr_new;
        end
    end

    // ------------------------------------------------------------------
    // Recovery FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        case (state)
            IDLE: begin
                if (mispredict) state_nxt = REDIRECT;
            end
            REDIRECT: begin
                if (!stall) begin
                    if (FLUSH_CYCLES == 1) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = FLUSH_LOAD;
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    if (flush_cnt == 4'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        flush_cnt_nxt = flush_cnt - 4'd1;
                    end
                end
            end
            default: begin
                state_nxt     = IDLE;
                flush_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Outputs are flopped from the next-state decode so they track the state
    // register exactly while staying glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect    <= 1'b0;
            flush       <= 1'b0;
            busy        <= 1'b0;
            redirect_pc <= 32'd0;
        end else begin
            redirect <= (state_nxt == REDIRECT);
            flush    <= (state_nxt == REDIRECT) || (state_nxt == FLUSH);
            busy     <= (state_nxt != IDLE);
            if (mispredict) begin
                redirect_pc <= ex_taken ? ex_target : fallthrough_pc;
            end
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches    <= 32'd0;
            perf_mispredicts <= 32'd0;
        end else begin
            if (accept && (perf_branches != 32'hFFFF_FFFF)) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (mispredict && (perf_mispredicts != 32'hFFFF_FFFF)) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

    localparam int IDX_W = 6;
    localparam int FC    = 2;
    localparam int DEPTH = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        busy;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    branch_redirect_ctrl #(.IDX_W(IDX_W), .FLUSH_CYCLES(FC)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_taken      (ex_taken),
        .ex_pred_taken (ex_pred_taken),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .busy          (busy)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: counters as plain integers 0..3, recovery as a count
    // of flush cycles still owed (first of them is the redirect cycle).
    int          m_bht [DEPTH];
    int          m_rec;
    logic [31:0] m_rpc;
    logic [31:0] m_pb;
    logic [31:0] m_pm;

    function automatic int midx(input logic [31:0] pc);
        return int'(pc / 4) % DEPTH;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
            m_rec = 0;
            m_rpc = 32'd0;
            m_pb  = 32'd0;
            m_pm  = 32'd0;
        end else if (m_rec > 0) begin
            if (!stall) m_rec--;
        end else if (ex_valid && ex_is_branch && !stall) begin
            int k;
            k = midx(ex_pc);
            if (ex_taken) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
            else          m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
            if (m_pb != 32'hFFFF_FFFF) m_pb++;
            if (ex_taken != ex_pred_taken) begin
                m_rec = FC;
                m_rpc = ex_taken ? ex_target : ex_pc + 32'd4;
                if (m_pm != 32'hFFFF_FFFF) m_pm++;
            end
        end
    endtask

    task automatic tick(input string tag);
        #1;
        if (!rst) check({tag, ":pred_pre"}, 32'(if_pred_taken), 32'(m_bht[midx(if_pc)] >= 2));
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ":redirect"},    32'(redirect), 32'(m_rec == FC));
        check({tag, ":flush"},       32'(flush),    32'(m_rec > 0));
        check({tag, ":busy"},        32'(busy),     32'(m_rec > 0));
        check({tag, ":redirect_pc"}, redirect_pc,   m_rpc);
        check({tag, ":pred"},        32'(if_pred_taken), 32'(m_bht[midx(if_pc)] >= 2));
`ifdef BRANCH_PERF_CNT_EN
        check({tag, ":perf_br"},  perf_branches,    m_pb);
        check({tag, ":perf_mis"}, perf_mispredicts, m_pm);
`endif
    endtask

    task automatic set_ex(input logic v, input logic b, input logic t, input logic p,
                          input logic [31:0] pc, input logic [31:0] tgt);
        ex_valid      = v;
        ex_is_branch  = b;
        ex_taken      = t;
        ex_pred_taken = p;
        ex_pc         = pc;
        ex_target     = tgt;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
        m_rec = 0; m_rpc = 32'd0; m_pb = 32'd0; m_pm = 32'd0;

        // Reset held two cycles, then sweep the table.
        rst = 1'b1; stall = 1'b0; if_pc = 32'd0;
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick("rst0");
        tick("rst1");
        rst = 1'b0;
        check("rst_redirect", 32'(redirect), 32'd0);
        check("rst_flush",    32'(flush),    32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_rpc",      redirect_pc,   32'd0);
        for (int a = 0; a < 'h100; a += 4) begin
            if_pc = 32'(a);
            #1;
            check("sweep_pred", 32'(if_pred_taken), 32'd0);
        end
        if_pc = 32'd0;
        tick("idle");

        // Taken mispredict.
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h80);
        tick("tmis");
        check("tmis_redirect", 32'(redirect), 32'd1);
        check("tmis_rpc",      redirect_pc,   32'h80);
        check("tmis_flush",    32'(flush),    32'd1);
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick("tmis2");
        check("tmis2_redirect", 32'(redirect), 32'd0);
        check("tmis2_flush",    32'(flush),    32'd1);
        tick("tmis3");
        check("tmis3_busy", 32'(busy), 32'd0);

        // Not-taken mispredict, fall-through wraps.
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234);
        tick("wrap");
        check("wrap_rpc", redirect_pc, 32'h0);
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick("wrap2");
        tick("wrap3");

        // Training and aliasing at 0x40 / 0x140.
        if_pc = 32'h40;
        set_ex(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0);
        #1;
        check("rbw_old", 32'(if_pred_taken), 32'd0);
        tick("train_t1");
        check("train_t1_pred", 32'(if_pred_taken), 32'd1);
        if_pc = 32'h140;
        #1;
        check("alias_pred", 32'(if_pred_taken), 32'd1);
        if_pc = 32'h40;
        tick("train_t2");
        tick("train_t3");
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        tick("train_n1");
        check("train_n1_pred", 32'(if_pred_taken), 32'd1);
        tick("train_n2");
        tick("train_n3");
        check("train_n3_pred", 32'(if_pred_taken), 32'd0);
        tick("train_n4");
        // From 00 a single taken update must still predict not-taken.
        set_ex(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0);
        tick("train_floor");
        check("train_floor_pred", 32'(if_pred_taken), 32'd0);

        // Stall in IDLE, then stall during REDIRECT.
        if_pc = 32'h208;
        stall = 1'b1;
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h208, 32'h300);
        repeat (3) tick("stall_idle");
        check("stall_idle_redirect", 32'(redirect), 32'd0);
        check("stall_idle_pred",     32'(if_pred_taken), 32'd0);
        stall = 1'b0;
        tick("stall_release");
        check("stall_release_redirect", 32'(redirect), 32'd1);
        check("stall_release_pred",     32'(if_pred_taken), 32'd1);
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        stall = 1'b1;
        tick("stall_redir1");
        tick("stall_redir2");
        check("stall_redir_hold", 32'(redirect), 32'd1);
        stall = 1'b0;
        tick("stall_redir_exit");
        tick("stall_flush_exit");

        // Wrong-path branch during recovery is ignored.
        if_pc = 32'h50C;
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h600);
        tick("wp_acc");
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h50C, 32'h0);
        tick("wp_redir");
        check("wp_redir_redirect", 32'(redirect), 32'd0);
        tick("wp_flush");
        check("wp_busy", 32'(busy), 32'd0);
        check("wp_rpc",  redirect_pc, 32'h600);
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick("wp_idle");

        // Reset during REDIRECT aborts recovery.
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h700, 32'h0);
        tick("abort_acc");
        check("abort_acc_redirect", 32'(redirect), 32'd1);
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        tick("abort_rst");
        check("abort_redirect", 32'(redirect), 32'd0);
        check("abort_flush",    32'(flush),    32'd0);
        check("abort_busy",     32'(busy),     32'd0);
        check("abort_rpc",      redirect_pc,   32'd0);
        rst = 1'b0;
        tick("abort_idle");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(99) == 0);
            stall = ($urandom_range(3) == 0);
            set_ex(1'($urandom_range(1)), ($urandom_range(3) != 0),
                   1'($urandom_range(1)), 1'($urandom_range(1)),
                   ($urandom_range(7) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                            : 32'($urandom_range(255)) << 2,
                   $urandom() & 32'hFFFF_FFFC);
            if_pc = ($urandom_range(1) == 1) ? ex_pc : 32'($urandom_range(255)) << 2;
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
